// File: rtl/move_ctrl.sv
// Player movement controller: synchronises and debounces five buttons, then turns
// press events into board moves, restarts and a win indication on an 8x8 grid.
module move_ctrl #(
   parameter int unsigned DEB_CYCLES = 16,
   parameter logic [2:0]  START_X    = 3'd0,
   parameter logic [2:0]  START_Y    = 3'd0,
   parameter logic [2:0]  GOAL_X     = 3'd7,
   parameter logic [2:0]  GOAL_Y     = 3'd7
) (
   input  logic       clk_d,
   input  logic       rst,
   input  logic       start_sw,
   input  logic [1:0] game_status,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_restart,
   output logic       active,
   output logic       reset_flag,
   output logic       win_flag,
   output logic [2:0] pos_x,
   output logic [2:0] pos_y
);

   typedef enum logic [1:0] {
      CHOSE_BOARD  = 2'b00,
      GAMING       = 2'b01,
      GAME_INITIAL = 2'b10,
      WINNED       = 2'b11
   } game_status_t;

   localparam int unsigned NBTN    = 5;
   localparam int unsigned B_RST   = 0;
   localparam int unsigned B_UP    = 1;
   localparam int unsigned B_DOWN  = 2;
   localparam int unsigned B_LEFT  = 3;
   localparam int unsigned B_RIGHT = 4;
   localparam logic [7:0]  DEB_MAX = 8'(DEB_CYCLES - 1);

   logic [NBTN-1:0] w_btn_raw;
   logic [NBTN-1:0] r_sync1;
   logic [NBTN-1:0] r_sync2;
   logic [NBTN-1:0] r_deb;
   logic [NBTN-1:0] r_deb_d;
   logic [7:0]      r_cnt [NBTN];
   logic [NBTN-1:0] w_press;

   logic [2:0]   w_nx_x;
   logic [2:0]   w_nx_y;
   logic         w_nx_win;
   logic         w_nx_active;
   logic         w_nx_rflag;
   logic         w_play_ok;
   logic         w_idle;
   game_status_t w_status;

   assign w_btn_raw = {btn_right, btn_left, btn_down, btn_up, btn_restart};
   assign w_press   = r_deb & ~r_deb_d;

   always_ff @(posedge clk_d or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_deb   <= '0;
         r_deb_d <= '0;
         for (int unsigned i = 0; i < NBTN; i++) r_cnt[i] <= '0;
      end else begin
         r_sync1 <= w_btn_raw;
         r_sync2 <= r_sync1;
         r_deb_d <= r_deb;
         for (int unsigned i = 0; i < NBTN; i++) begin
            if (r_sync2[i] != r_deb[i]) begin
               if (r_cnt[i] == DEB_MAX) begin
                  r_deb[i] <= r_sync2[i];
                  r_cnt[i] <= '0;
               end else begin
                  r_cnt[i] <= r_cnt[i] + 8'd1;
               end
            end else begin
               r_cnt[i] <= '0;
            end
         end
      end
   end

   // Events arriving the cycle right after a pulse are dropped so that pulses never
   // run back to back, even when different buttons settle on adjacent cycles.
   always_comb begin
      w_nx_x      = pos_x;
      w_nx_y      = pos_y;
      w_nx_win    = win_flag;
      w_nx_active = 1'b0;
      w_nx_rflag  = 1'b0;
      w_status    = game_status_t'(game_status);
      w_play_ok   = (w_status == GAMING || w_status == GAME_INITIAL) && !win_flag;
      w_idle      = !active && !reset_flag;
      if (!start_sw) begin
         w_nx_x   = START_X;
         w_nx_y   = START_Y;
         w_nx_win = 1'b0;
      end else if (w_idle) begin
         if (w_press[B_RST]) begin
            w_nx_x     = START_X;
            w_nx_y     = START_Y;
            w_nx_win   = 1'b0;
            w_nx_rflag = 1'b1;
         end else if (w_press[B_UP]) begin
            if (w_play_ok && pos_y != 3'd0) begin
               w_nx_y      = pos_y - 3'd1;
               w_nx_active = 1'b1;
            end
         end else if (w_press[B_DOWN]) begin
            if (w_play_ok && pos_y != 3'd7) begin
               w_nx_y      = pos_y + 3'd1;
               w_nx_active = 1'b1;
            end
         end else if (w_press[B_LEFT]) begin
            if (w_play_ok && pos_x != 3'd0) begin
               w_nx_x      = pos_x - 3'd1;
               w_nx_active = 1'b1;
            end
         end else if (w_press[B_RIGHT]) begin
            if (w_play_ok && pos_x != 3'd7) begin
               w_nx_x      = pos_x + 3'd1;
               w_nx_active = 1'b1;
            end
         end
         if (w_nx_active && w_nx_x == GOAL_X && w_nx_y == GOAL_Y) w_nx_win = 1'b1;
      end
   end

   always_ff @(posedge clk_d or posedge rst) begin
      if (rst) begin
         pos_x      <= START_X;
         pos_y      <= START_Y;
         win_flag   <= 1'b0;
         active     <= 1'b0;
         reset_flag <= 1'b0;
      end else begin
         pos_x      <= w_nx_x;
         pos_y      <= w_nx_y;
         win_flag   <= w_nx_win;
         active     <= w_nx_active;
         reset_flag <= w_nx_rflag;
      end
   end

endmodule
